// File: rtl/uart_pkg.sv
// Shared types, status-bit positions and baud divisor helper for the UART core.
package uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int unsigned TX_FULL  = 0;
  localparam int unsigned TX_EMPTY = 1;
  localparam int unsigned TX_BUSY  = 2;
  localparam int unsigned TX_OVF   = 3;
  localparam int unsigned RX_VALID = 8;
  localparam int unsigned RX_OVR   = 9;
  localparam int unsigned RX_FE    = 10;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Register port between the CPU IO decoder (io) and the UART peripheral (uart).
interface if_io;
  logic [31:0] UART_TX_WD;
  logic        UART_TX_WE;
  logic        UART_TX_A;
  logic        UART_RX_WE;
  logic        UART_RX_RE;
  logic        UART_RX_A;
  logic [31:0] UART_TX_RD;
  logic [31:0] UART_RX_RD;

  modport uart (
    input  UART_TX_WD, UART_TX_WE, UART_TX_A, UART_RX_WE, UART_RX_RE, UART_RX_A,
    output UART_TX_RD, UART_RX_RD
  );

  modport io (
    output UART_TX_WD, UART_TX_WE, UART_TX_A, UART_RX_WE, UART_RX_RE, UART_RX_A,
    input  UART_TX_RD, UART_RX_RD
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_core.sv
// Buffered 8N1 UART: TX FIFO feeding a serializer, RX deserializer feeding an RX FIFO.
module uart_core #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic      CLK,
  input  logic      RESET_N,
  if_io.uart        IO,
  input  logic      RXD,
  output logic      TXD
);
  import uart_pkg::*;

  localparam int unsigned    DIV         = calc_div(CLK_HZ, BAUD);
  localparam int unsigned    CW          = $clog2(DIV);
  localparam logic [CW-1:0]  BIT_RELOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0]  HALF_RELOAD = CW'(DIV / 2 - 1);

  logic tx_push, tx_ctl_wr, rx_pop, rx_ctl_wr;
  assign tx_push   = IO.UART_TX_WE & ~IO.UART_TX_A;
  assign tx_ctl_wr = IO.UART_TX_WE &  IO.UART_TX_A;
  assign rx_pop    = IO.UART_RX_RE & ~IO.UART_RX_A;
  assign rx_ctl_wr = IO.UART_RX_WE &  IO.UART_RX_A;

  logic unused_wd;
  assign unused_wd = ^{IO.UART_TX_WD[31:11], IO.UART_TX_WD[8]};

  // ---------------- TX ----------------
  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(CLK), .rst_n(RESET_N), .push(tx_push), .pop(tx_pop),
    .din(IO.UART_TX_WD[7:0]), .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          txd_n, tx_ovf;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      TXD      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      TXD      <= txd_n;
    end
  end

  // TXD is registered, so each transition drives the level of the state being entered.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = TXD;
    tx_pop     = 1'b0;
    if (tx_state != TX_IDLE && tx_cnt != '0) tx_cnt_n = tx_cnt - 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_state_n = TX_START;
          tx_cnt_n   = BIT_RELOAD;
          tx_shift_n = tx_head;
          tx_pop     = 1'b1;
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = BIT_RELOAD;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = BIT_RELOAD;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (!tx_empty) begin
            tx_state_n = TX_START;
            tx_cnt_n   = BIT_RELOAD;
            tx_shift_n = tx_head;
            tx_pop     = 1'b1;
            txd_n      = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            txd_n      = 1'b1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                                tx_ovf <= 1'b0;
    else if (tx_push & tx_full & ~tx_pop)        tx_ovf <= 1'b1;
    else if (tx_ctl_wr & IO.UART_TX_WD[TX_OVF])  tx_ovf <= 1'b0;
  end

  always_comb begin
    IO.UART_TX_RD           = '0;
    IO.UART_TX_RD[TX_FULL]  = tx_full;
    IO.UART_TX_RD[TX_EMPTY] = tx_empty;
    IO.UART_TX_RD[TX_BUSY]  = ~tx_empty | (tx_state != TX_IDLE);
    IO.UART_TX_RD[TX_OVF]   = tx_ovf;
  end

  // ---------------- RX ----------------
  logic rxd_s1, rxd_s2, rxd_prev;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= RXD;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_hold, rx_hold_n;
  logic          rx_push, rx_fe_set;
  logic          rx_full, rx_empty, rx_ovr, rx_fe;
  logic [7:0]    rx_head;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_hold  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_hold  <= rx_hold_n;
    end
  end

  // rx_hold keeps a framing-error frame in STOP until the line is released high.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_hold_n  = rx_hold;
    rx_push    = 1'b0;
    rx_fe_set  = 1'b0;
    if (rx_state != RX_IDLE && rx_cnt != '0) rx_cnt_n = rx_cnt - 1'b1;
    case (rx_state)
      RX_IDLE: begin
        if (rxd_prev & ~rxd_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rxd_s2) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = BIT_RELOAD;
            rx_bit_n   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_n = {rxd_s2, rx_shift[7:1]};
          rx_cnt_n   = BIT_RELOAD;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_hold) begin
          if (rxd_s2) begin
            rx_state_n = RX_IDLE;
            rx_hold_n  = 1'b0;
          end
        end else if (rx_cnt == '0) begin
          if (rxd_s2) begin
            rx_push    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_fe_set  = 1'b1;
            rx_hold_n  = 1'b1;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(CLK), .rst_n(RESET_N), .push(rx_push), .pop(rx_pop),
    .din(rx_shift), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_ovr <= 1'b0;
      rx_fe  <= 1'b0;
    end else begin
      if (rx_push & rx_full & ~rx_pop)             rx_ovr <= 1'b1;
      else if (rx_ctl_wr & IO.UART_TX_WD[RX_OVR])  rx_ovr <= 1'b0;
      if (rx_fe_set)                               rx_fe  <= 1'b1;
      else if (rx_ctl_wr & IO.UART_TX_WD[RX_FE])   rx_fe  <= 1'b0;
    end
  end

  always_comb begin
    IO.UART_RX_RD           = '0;
    IO.UART_RX_RD[7:0]      = rx_empty ? 8'h00 : rx_head;
    IO.UART_RX_RD[RX_VALID] = ~rx_empty;
    IO.UART_RX_RD[RX_OVR]   = rx_ovr;
    IO.UART_RX_RD[RX_FE]    = rx_fe;
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core with DIV=16: exact TX waveform, back-to-back TX, RX paths, reset.
module tb_uart_core;
  localparam int unsigned DIV   = 16;
  localparam int unsigned DEPTH = 8;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic RXD = 1'b1;
  logic TXD;

  if_io io_bus();

  uart_core #(.CLK_HZ(16), .BAUD(1), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IO(io_bus), .RXD(RXD), .TXD(TXD)
  );

  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic step(input int unsigned n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Line-level receiver watching TXD: samples mid-bit, records byte and start cycle.
  typedef struct { int unsigned t; logic [7:0] d; } mon_t;
  mon_t mon_q[$];
  logic mon_ok;

  task automatic mon_wait(input int unsigned n);
    repeat (n) begin @(posedge CLK); #1; if (!RESET_N) mon_ok = 1'b0; end
  endtask

  initial begin : tx_monitor
    int unsigned t0;
    logic [7:0]  b;
    forever begin
      @(posedge CLK); #1;
      if (RESET_N && TXD === 1'b0) begin
        t0 = cyc;
        mon_ok = 1'b1;
        mon_wait(DIV / 2);
        if (TXD !== 1'b0) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin mon_wait(DIV); b[i] = TXD; end
        mon_wait(DIV);
        if (TXD !== 1'b1) mon_ok = 1'b0;
        if (mon_ok) mon_q.push_back('{t0, b});
      end
    end
  end

  task automatic bus_idle();
    io_bus.UART_TX_WD = '0;
    io_bus.UART_TX_WE = 1'b0;
    io_bus.UART_TX_A  = 1'b0;
    io_bus.UART_RX_WE = 1'b0;
    io_bus.UART_RX_RE = 1'b0;
    io_bus.UART_RX_A  = 1'b0;
  endtask

  task automatic tx_write(input logic a, input logic [31:0] wd);
    io_bus.UART_TX_WE = 1'b1; io_bus.UART_TX_A = a; io_bus.UART_TX_WD = wd;
    step();
    bus_idle();
  endtask

  task automatic rx_write(input logic a, input logic [31:0] wd);
    io_bus.UART_RX_WE = 1'b1; io_bus.UART_RX_A = a; io_bus.UART_TX_WD = wd;
    step();
    bus_idle();
  endtask

  task automatic rx_read(input logic a);
    io_bus.UART_RX_RE = 1'b1; io_bus.UART_RX_A = a;
    step();
    bus_idle();
  endtask

  // One 8N1 frame on RXD. The stop sample lands 2 (sync) + 1 (edge) + DIV/2 + 9*DIV clocks
  // after the start bit is driven, i.e. iteration 154; pop_at_push lines a pop up with it.
  task automatic send_rx(input logic [7:0] d, input logic stop, input logic pop_at_push);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int c = 0; c < 10 * DIV; c++) begin
      RXD = fr[c / DIV];
      io_bus.UART_RX_RE = pop_at_push && (c == 154);
      io_bus.UART_RX_A  = 1'b0;
      step();
    end
    io_bus.UART_RX_RE = 1'b0;
    RXD = 1'b1;
  endtask

  task automatic test_reset();
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", TXD); end
    checks++; if (io_bus.UART_TX_RD !== 32'h2) begin errors++; $display("FAIL reset_tx_rd got %h exp %h", io_bus.UART_TX_RD, 32'h2); end
    checks++; if (io_bus.UART_RX_RD !== 32'h0) begin errors++; $display("FAIL reset_rx_rd got %h exp %h", io_bus.UART_RX_RD, 32'h0); end
  endtask

  task automatic test_tx_frame(input logic [7:0] d);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    mon_q.delete();
    io_bus.UART_TX_WE = 1'b1; io_bus.UART_TX_A = 1'b0; io_bus.UART_TX_WD = {24'hABCDEF, d};
    step();
    bus_idle();
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL tx_pre_load_txd got %b exp 1", TXD); end
    checks++; if (io_bus.UART_TX_RD !== 32'h4) begin errors++; $display("FAIL tx_queued_rd got %h exp %h", io_bus.UART_TX_RD, 32'h4); end
    for (int i = 0; i < 10 * DIV; i++) begin
      step();
      checks++; if (TXD !== fr[i / DIV]) begin errors++; $display("FAIL tx_wave clk %0d got %b exp %b", i + 1, TXD, fr[i / DIV]); end
      checks++; if (io_bus.UART_TX_RD[2] !== 1'b1) begin errors++; $display("FAIL tx_busy clk %0d got %b exp 1", i + 1, io_bus.UART_TX_RD[2]); end
    end
    step();
    checks++; if (io_bus.UART_TX_RD !== 32'h2) begin errors++; $display("FAIL tx_done_rd got %h exp %h", io_bus.UART_TX_RD, 32'h2); end
    checks++; if (mon_q.size() != 1) begin errors++; $display("FAIL tx_mon_count got %0d exp 1", mon_q.size()); end
    else begin
      checks++; if (mon_q[0].d !== d) begin errors++; $display("FAIL tx_mon_byte got %h exp %h", mon_q[0].d, d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [10];
    logic [7:0] q [$];
    logic [7:0] sent [$];
    logic       ovf;
    logic [31:0] exp;
    int unsigned k;
    mon_q.delete();
    ovf = 1'b0;
    for (int j = 0; j < 10; j++) b[j] = 8'($urandom);
    for (int j = 0; j < 10; j++) begin
      io_bus.UART_TX_WE = 1'b1; io_bus.UART_TX_A = 1'b0; io_bus.UART_TX_WD = {24'h0, b[j]};
      step();
      // The serializer takes the first byte one clock after it is written, freeing a slot.
      if (j == 1) sent.push_back(q.pop_front());
      if (q.size() < DEPTH) q.push_back(b[j]); else ovf = 1'b1;
      exp = {28'h0, ovf, 1'b1, q.size() == 0, q.size() == DEPTH};
      checks++; if (io_bus.UART_TX_RD !== exp) begin errors++; $display("FAIL b2b_write%0d_rd got %h exp %h", j, io_bus.UART_TX_RD, exp); end
    end
    bus_idle();
    tx_write(1'b1, 32'h8);
    checks++; if (io_bus.UART_TX_RD !== 32'h5) begin errors++; $display("FAIL b2b_ovf_clear got %h exp %h", io_bus.UART_TX_RD, 32'h5); end
    while (q.size() > 0) sent.push_back(q.pop_front());
    k = 0;
    while (k < 9 * 10 * DIV + 200 && mon_q.size() < sent.size()) begin step(); k++; end
    checks++; if (mon_q.size() != sent.size()) begin errors++; $display("FAIL b2b_frames got %0d exp %0d", mon_q.size(), sent.size()); end
    else begin
      for (int i = 0; i < sent.size(); i++) begin
        checks++; if (mon_q[i].d !== sent[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, mon_q[i].d, sent[i]); end
        if (i > 0) begin
          checks++; if (mon_q[i].t - mon_q[i-1].t != 10 * DIV) begin errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", i, mon_q[i].t - mon_q[i-1].t, 10 * DIV); end
        end
      end
    end
    step(200);
    checks++; if (mon_q.size() != sent.size()) begin errors++; $display("FAIL b2b_extra_frames got %0d exp %0d", mon_q.size(), sent.size()); end
    checks++; if (io_bus.UART_TX_RD !== 32'h2) begin errors++; $display("FAIL b2b_idle_rd got %h exp %h", io_bus.UART_TX_RD, 32'h2); end
  endtask

  task automatic test_rx_basic();
    logic [7:0] d [2];
    d[0] = 8'hA3;
    d[1] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      send_rx(d[i], 1'b1, 1'b0);
      checks++; if (io_bus.UART_RX_RD !== {23'h0, 1'b1, d[i]}) begin errors++; $display("FAIL rx_byte%0d got %h exp %h", i, io_bus.UART_RX_RD, {23'h0, 1'b1, d[i]}); end
      rx_read(1'b1);
      checks++; if (io_bus.UART_RX_RD !== {23'h0, 1'b1, d[i]}) begin errors++; $display("FAIL rx_read_a1 got %h exp %h", io_bus.UART_RX_RD, {23'h0, 1'b1, d[i]}); end
      rx_read(1'b0);
      checks++; if (io_bus.UART_RX_RD !== 32'h0) begin errors++; $display("FAIL rx_pop got %h exp %h", io_bus.UART_RX_RD, 32'h0); end
    end
    rx_read(1'b0);
    checks++; if (io_bus.UART_RX_RD !== 32'h0) begin errors++; $display("FAIL rx_pop_empty got %h exp %h", io_bus.UART_RX_RD, 32'h0); end
  endtask

  task automatic test_rx_glitch_fe();
    logic [7:0] d;
    RXD = 1'b0; step(4); RXD = 1'b1; step(40);
    checks++; if (io_bus.UART_RX_RD !== 32'h0) begin errors++; $display("FAIL rx_glitch got %h exp %h", io_bus.UART_RX_RD, 32'h0); end
    send_rx(8'($urandom), 1'b0, 1'b0);
    step(5);
    checks++; if (io_bus.UART_RX_RD !== 32'h400) begin errors++; $display("FAIL rx_fe_set got %h exp %h", io_bus.UART_RX_RD, 32'h400); end
    rx_write(1'b0, 32'h400);
    checks++; if (io_bus.UART_RX_RD !== 32'h400) begin errors++; $display("FAIL rx_fe_a0_ignored got %h exp %h", io_bus.UART_RX_RD, 32'h400); end
    rx_write(1'b1, 32'h400);
    checks++; if (io_bus.UART_RX_RD !== 32'h0) begin errors++; $display("FAIL rx_fe_clear got %h exp %h", io_bus.UART_RX_RD, 32'h0); end
    d = 8'($urandom);
    send_rx(d, 1'b1, 1'b0);
    checks++; if (io_bus.UART_RX_RD !== {23'h0, 1'b1, d}) begin errors++; $display("FAIL rx_after_fe got %h exp %h", io_bus.UART_RX_RD, {23'h0, 1'b1, d}); end
    rx_read(1'b0);
  endtask

  task automatic test_rx_overrun();
    logic [7:0]  q [$];
    logic        ovr;
    logic [7:0]  d;
    logic [31:0] exp;
    ovr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      d = 8'($urandom);
      send_rx(d, 1'b1, 1'b0);
      if (q.size() < DEPTH) q.push_back(d); else ovr = 1'b1;
      exp = {21'h0, 1'b0, ovr, 1'b1, q[0]};
      checks++; if (io_bus.UART_RX_RD !== exp) begin errors++; $display("FAIL ovr_frame%0d got %h exp %h", k, io_bus.UART_RX_RD, exp); end
    end
    d = 8'($urandom);
    send_rx(d, 1'b1, 1'b1);
    void'(q.pop_front());
    q.push_back(d);
    exp = {21'h0, 1'b0, ovr, 1'b1, q[0]};
    checks++; if (io_bus.UART_RX_RD !== exp) begin errors++; $display("FAIL ovr_pop_push got %h exp %h", io_bus.UART_RX_RD, exp); end
    while (q.size() > 0) begin
      exp = {21'h0, 1'b0, ovr, 1'b1, q[0]};
      checks++; if (io_bus.UART_RX_RD !== exp) begin errors++; $display("FAIL ovr_drain%0d got %h exp %h", q.size(), io_bus.UART_RX_RD, exp); end
      rx_read(1'b0);
      void'(q.pop_front());
    end
    checks++; if (io_bus.UART_RX_RD !== 32'h200) begin errors++; $display("FAIL ovr_empty got %h exp %h", io_bus.UART_RX_RD, 32'h200); end
    rx_write(1'b1, 32'h200);
    checks++; if (io_bus.UART_RX_RD !== 32'h0) begin errors++; $display("FAIL ovr_clear got %h exp %h", io_bus.UART_RX_RD, 32'h0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    send_rx(8'($urandom), 1'b1, 1'b0);
    checks++; if (io_bus.UART_RX_RD[8] !== 1'b1) begin errors++; $display("FAIL rst_rx_loaded got %b exp 1", io_bus.UART_RX_RD[8]); end
    d = 8'($urandom) & 8'hFE;
    tx_write(1'b0, {24'h0, d});
    step(24);
    checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL rst_mid_bit0 got %b exp 0", TXD); end
    mon_q.delete();
    RESET_N = 1'b0;
    #1;
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL rst_async_txd got %b exp 1", TXD); end
    step(3);
    RESET_N = 1'b1;
    step();
    checks++; if (io_bus.UART_TX_RD !== 32'h2) begin errors++; $display("FAIL rst_tx_rd got %h exp %h", io_bus.UART_TX_RD, 32'h2); end
    checks++; if (io_bus.UART_RX_RD !== 32'h0) begin errors++; $display("FAIL rst_rx_rd got %h exp %h", io_bus.UART_RX_RD, 32'h0); end
    step(200);
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL rst_txd_idle got %b exp 1", TXD); end
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL rst_no_frame got %0d exp 0", mon_q.size()); end
  endtask

  initial begin : watchdog
    #(100000 * 10);
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus_idle();
    RESET_N = 1'b0;
    step(3);
    RESET_N = 1'b1;
    step();
    test_reset();
    test_tx_frame(8'h55);
    test_tx_frame(8'($urandom));
    test_back_to_back();
    test_rx_basic();
    test_rx_glitch_fe();
    test_rx_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
